sumador_segmentado: RTL
=======================

Name: sumador_segmentado

Overview:
- Parametrised pipelined adder/subtractor, the successor of the 32-bit combinational adder.
- Splits a WIDTH-bit add into WIDTH/SEG ripple segments, one segment per register stage, so wide operands close timing on the FPGA.
- Adds subtract mode, signed-overflow and zero flags, and valid/ready handshakes with back-pressure.
- Sits between the operand registers and the ALU result bus.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SEG.
- SEG, 8, bits added per pipeline stage. STAGES = WIDTH/SEG. WIDTH % SEG != 0 is an elaboration error.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  operands/mode valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- SumandoA  input  WIDTH  operand A.
- SumandoB  input  WIDTH  operand B.
- Acarreo  input  1  carry-in (add mode only).
- Resta  input  1  0 = A+B+Acarreo; 1 = A-B (A + ~B + 1, Acarreo ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Resultado  output  WIDTH  sum/difference.
- AcarreoSalida  output  1  carry out of bit WIDTH-1; in subtract mode 1 = no borrow.
- Desbordamiento  output  1  two's-complement overflow.
- Cero  output  1  Resultado == 0.

Behaviour:
- Reset (synchronous):
  - Clears every stage valid bit and all data registers.
  - Outputs read 0: Resultado, AcarreoSalida, Desbordamiento, Cero, out_valid.
  - in_ready = 0 while reset is high.
  - In-flight operations are discarded; nothing emerges after reset releases.
- Effective operand: Beff = Resta ? ~SumandoB : SumandoB. Effective carry-in: cin = Resta ? 1 : Acarreo.
- Stage k (k = 0..STAGES-1):
  - Adds segment k of A and Beff plus the carry registered by stage k-1 (stage 0 uses cin).
  - Registers the SEG-bit partial sum, the carry out, and the not-yet-added upper segments of A and Beff.
  - Lower result segments shift forward unchanged.
- Latency: exactly STAGES cycles from an accepted input (in_valid & in_ready on edge N) to out_valid at edge N+STAGES. Default configuration: 4 cycles.
- Throughput: one operation per cycle when out_ready = 1.
- Handshake:
  - stall = out_valid & ~out_ready.
  - When stalled, every stage holds its contents.
  - in_ready = ~reset & ~stall, combinational.
  - Output data and flags stay stable while out_valid & ~out_ready.
  - Bubbles (invalid stages) advance even when stalled only if the output stage is empty. With the global-stall scheme, the whole pipe freezes only when the output holds valid data.
- Flags, computed in the final stage and registered with Resultado:
  - AcarreoSalida = carry out of the top segment.
  - Desbordamiento = (A[WIDTH-1] == Beff[WIDTH-1]) & (Resultado[WIDTH-1] != A[WIDTH-1]).
  - Cero = (Resultado == 0), evaluated on the final (possibly saturated) value.
- Wrap-around: results are modulo 2^WIDTH unless saturation is enabled.
- Simultaneous accept and emit in the same cycle is legal; no bubble is inserted.
- in_valid while in_ready = 0: operands are ignored; the producer must hold them.

Optional Feature:
- Macro: SUMADOR_SATURACION_EN.
- Defined: when Desbordamiento = 1, Resultado saturates to the signed limit.
  - 0111..1 if A[WIDTH-1] = 0.
  - 1000..0 if A[WIDTH-1] = 1.
  - Desbordamiento is still asserted; AcarreoSalida is unchanged (raw carry).
  - Saturation is applied in the final stage; latency is unchanged.
- Not defined: the wrapped result is output; no saturation logic is present.

Test Plan (WIDTH=32, SEG=8):
- Basic latency: A=0x0000_00FF, B=0x0000_0001, Acarreo=0, Resta=0 -> after 4 cycles Resultado=0x0000_0100, AcarreoSalida=0, Desbordamiento=0, Cero=0.
- Carry ripple across all stages: A=0xFFFF_FFFF, B=0, Acarreo=1 -> Resultado=0, AcarreoSalida=1, Cero=1, Desbordamiento=0.
- Subtract with borrow: Resta=1, A=5, B=7 -> Resultado=0xFFFF_FFFE, AcarreoSalida=0. Then A=7, B=5 -> Resultado=2, AcarreoSalida=1.
- Signed overflow: A=0x7FFF_FFFF, B=1, add -> Desbordamiento=1. Resultado=0x8000_0000 without the macro, 0x7FFF_FFFF with SUMADOR_SATURACION_EN.
- Back-pressure: stream 6 back-to-back operations (i+1)+(i+1); hold out_ready=0 for 3 cycles after the first output -> in_ready=0 during the hold, output stable; all 6 results 2,4,...,12 delivered in order, none lost or duplicated.
- Reset mid-operation: accept 3 operations, assert reset for 1 cycle at the 2nd cycle -> out_valid stays 0 and no results appear; a new op 10+20 after reset yields 30 in 4 cycles.

Source files
------------

// File: rtl/sumador_segmentado.sv
// Pipelined adder/subtractor: one SEG-bit ripple segment per register stage, flags on the output stage.
// Optional SUMADOR_SATURACION_EN clamps overflowing results to the signed limit.
module sumador_segmentado #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SumandoA,
  input  logic [WIDTH-1:0] SumandoB,
  input  logic             Acarreo,
  input  logic             Resta,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Resultado,
  output logic             AcarreoSalida,
  output logic             Desbordamiento,
  output logic             Cero
);

  localparam int STAGES = WIDTH / SEG;

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_width_check
    $error("sumador_segmentado: WIDTH must be a non-zero multiple of SEG");
  end

  // Handshake: a transfer happens on any rising edge where valid and ready are both high;
  // the whole pipe freezes only while the output holds a result the consumer has not taken.
  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~reset & ~stall;

  // Level k holds operands plus the sum of segments 0..k-1 and the carry into segment k.
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             v_q   [STAGES];

  logic [SEG:0]     seg_sum [STAGES];
  logic [WIDTH-1:0] s_next  [STAGES];

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, a_q[k][k*SEG +: SEG]} + {1'b0, b_q[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_q[k]};
      s_next[k]  = s_q[k];
      s_next[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
    end
  end

  logic [WIDTH-1:0] sum_full;
  logic [WIDTH-1:0] res_fin;
  logic             a_sign;
  logic             b_sign;
  logic             ovf;

  assign sum_full = s_next[STAGES-1];
  assign a_sign   = a_q[STAGES-1][WIDTH-1];
  assign b_sign   = b_q[STAGES-1][WIDTH-1];
  assign ovf      = (a_sign == b_sign) & (sum_full[WIDTH-1] != a_sign);

`ifdef SUMADOR_SATURACION_EN
  assign res_fin = ovf ? (a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                       : sum_full;
`else
  assign res_fin = sum_full;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      out_valid      <= 1'b0;
      Resultado      <= '0;
      AcarreoSalida  <= 1'b0;
      Desbordamiento <= 1'b0;
      Cero           <= 1'b0;
    end else if (!stall) begin
      a_q[0] <= SumandoA;
      b_q[0] <= Resta ? ~SumandoB : SumandoB;
      s_q[0] <= '0;
      c_q[0] <= Resta ? 1'b1 : Acarreo;
      v_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        s_q[k] <= s_next[k-1];
        c_q[k] <= seg_sum[k-1][SEG];
        v_q[k] <= v_q[k-1];
      end
      out_valid      <= v_q[STAGES-1];
      Resultado      <= res_fin;
      AcarreoSalida  <= seg_sum[STAGES-1][SEG];
      Desbordamiento <= ovf;
      Cero           <= (res_fin == '0);
    end
  end

endmodule
